// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the load/store port; one request at a time,
// fixed accept-to-response latency, extended loads, error flagging.
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rdy_q, we_q, uns_q, err_q, err_d;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
    logic [31:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0] word, sh, ld, wd, mask;
    logic        err, accept, commit;
    assign idx    = addr_q[ADDR_WIDTH+1:2];
    assign word   = mem[idx];
    assign sh     = word >> {addr_q[1:0], 3'b000};
    assign accept = state_q == IDLE && req_valid && rdy_q;
    assign commit = state_q == WAIT && cnt_q == 4'd0;
    assign err = size_q == 2'b11 || (size_q == 2'b01 && addr_q[0]) ||
                 (size_q == 2'b10 && addr_q[1:0] != 2'b00) || |addr_q[31:ADDR_WIDTH+2];
    assign ld = size_q == 2'b00 ? {{24{sh[7] & ~uns_q}}, sh[7:0]} :
                size_q == 2'b01 ? {{16{sh[15] & ~uns_q}}, sh[15:0]} : word;
    assign wd = size_q == 2'b00 ? {4{wdata_q[7:0]}} :
                size_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    assign mask = size_q == 2'b00 ? 32'hFF << {addr_q[1:0], 3'b000} :
                  size_q == 2'b01 ? (addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : 32'hFFFF_FFFF;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = WAIT;
                cnt_d   = 4'(LATENCY - 1);
            end
            WAIT: if (cnt_q == 4'd0) begin
                state_d = RESP;
                rdata_d = (err || we_q) ? 32'd0 : ld;
                err_d   = err;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    // ready is registered so it rises only at the first edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= state_d == IDLE;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (commit && we_q && !err && !rst)
            mem[idx] <= (word & ~mask) | (wd & mask);
    end
    assign req_ready = rdy_q;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule
